// File: rtl/nes_joypad_scan_if.sv
`default_nettype none
// nes_joypad_scan_if -- pad-side and console-side signals of the dual joypad scanner (rev 1.0)
interface nes_joypad_scan_if;
  logic       o_pad_latch;
  logic       o_pad_clk;
  logic       i_pad1_data;
  logic       i_pad2_data;
  logic [3:0] i_aux_n;
  logic [9:0] o_jp_vec_1p;
  logic [9:0] o_jp_vec_2p;
  logic       o_scan_done;

  modport master (
    output o_pad_latch, o_pad_clk, o_jp_vec_1p, o_jp_vec_2p, o_scan_done,
    input  i_pad1_data, i_pad2_data, i_aux_n
  );

  modport slave (
    input  o_pad_latch, o_pad_clk, o_jp_vec_1p, o_jp_vec_2p, o_scan_done,
    output i_pad1_data, i_pad2_data, i_aux_n
  );
endinterface
`default_nettype wire

// File: rtl/nes_joypad_scan.sv
`default_nettype none
// nes_joypad_scan -- periodic latch/shift scanner for two NES pads, atomic vector publish (rev 1.0)
module nes_joypad_scan #(
  parameter int unsigned HALF_PER = 6,
  parameter int unsigned SCAN_GAP = 29830
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst,
  input  wire logic         i_scan_en,
  nes_joypad_scan_if.master bus
);

  localparam logic [8:0]  c_LATCH_LAST = 9'(2 * HALF_PER - 1);
  localparam logic [8:0]  c_HALF_LAST  = 9'(HALF_PER - 1);
  localparam logic [19:0] c_GAP_LAST   = 20'(SCAN_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t      r_state, w_next;
  logic [8:0]  r_phase;
  logic [2:0]  r_idx;
  logic [19:0] r_gap;
  logic [7:0]  r_sh1, r_sh2, w_sh1_next, w_sh2_next;
  logic        r_p1_m, r_p1_s, r_p2_m, r_p2_s;
  logic [3:0]  r_aux_m, r_aux_s;
  logic        r_latch, r_pclk, r_done;
  logic [9:0]  r_vec1, r_vec2;
  logic        w_phase_last, w_gap_top, w_sample;

  assign w_phase_last = (r_state == S_LATCH) ? (r_phase == c_LATCH_LAST)
                                             : (r_phase == c_HALF_LAST);
  assign w_gap_top    = (r_gap == c_GAP_LAST);
  assign w_sample     = (r_state == S_SHIFT_HI) && w_phase_last;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_gap_top && i_scan_en) w_next = S_LATCH;
      S_LATCH:    if (w_phase_last) w_next = S_SHIFT_HI;
      S_SHIFT_HI: if (w_phase_last) w_next = (r_idx == 3'd7) ? S_DONE : S_SHIFT_LO;
      S_SHIFT_LO: if (w_phase_last) w_next = S_SHIFT_HI;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Shadow bit for the current index is captured on the last high-phase cycle.
  always_comb begin
    w_sh1_next = r_sh1;
    w_sh2_next = r_sh2;
    if (w_sample) begin
      w_sh1_next[r_idx] = ~r_p1_s;
      w_sh2_next[r_idx] = ~r_p2_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p1_m  <= 1'b1;
      r_p1_s  <= 1'b1;
      r_p2_m  <= 1'b1;
      r_p2_s  <= 1'b1;
      r_aux_m <= 4'hF;
      r_aux_s <= 4'hF;
    end else begin
      r_p1_m  <= bus.i_pad1_data;
      r_p1_s  <= r_p1_m;
      r_p2_m  <= bus.i_pad2_data;
      r_p2_s  <= r_p2_m;
      r_aux_m <= bus.i_aux_n;
      r_aux_s <= r_aux_m;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= 9'd0;
      r_idx   <= 3'd0;
      r_gap   <= 20'd0;
      r_sh1   <= 8'h00;
      r_sh2   <= 8'h00;
    end else begin
      if (w_next != r_state || r_state == S_IDLE || r_state == S_DONE)
        r_phase <= 9'd0;
      else
        r_phase <= r_phase + 9'd1;

      if (r_state == S_LATCH)
        r_idx <= 3'd0;
      else if (w_sample && r_idx != 3'd7)
        r_idx <= r_idx + 3'd1;

      // Cleared on entry to DONE so the DONE cycle counts as the first gap cycle.
      if (w_next == S_DONE)
        r_gap <= 20'd0;
      else if ((r_state == S_IDLE || r_state == S_DONE) && !w_gap_top)
        r_gap <= r_gap + 20'd1;

      r_sh1 <= w_sh1_next;
      r_sh2 <= w_sh2_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_latch <= 1'b0;
      r_pclk  <= 1'b1;
      r_done  <= 1'b0;
      r_vec1  <= 10'h000;
      r_vec2  <= 10'h000;
    end else begin
      r_latch <= (w_next == S_LATCH);
      r_pclk  <= (w_next != S_SHIFT_LO);
      r_done  <= (w_next == S_DONE);
      if (w_next == S_DONE) begin
        r_vec1 <= {~r_aux_s[1:0], w_sh1_next};
        r_vec2 <= {~r_aux_s[3:2], w_sh2_next};
      end
    end
  end

  assign bus.o_pad_latch = r_latch;
  assign bus.o_pad_clk   = r_pclk;
  assign bus.o_scan_done = r_done;
  assign bus.o_jp_vec_1p = r_vec1;
  assign bus.o_jp_vec_2p = r_vec2;

endmodule
`default_nettype wire

// File: tb/tb_nes_joypad_scan.sv
`default_nettype none
// tb_nes_joypad_scan -- directed scoreboard bench with behavioural 4021-style pad models (rev 1.0)
module tb_nes_joypad_scan;
  localparam int HP  = 6;
  localparam int GAP = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_en = 1'b0;
  always #5 clk = ~clk;

  nes_joypad_scan_if bus();

  nes_joypad_scan #(.HALF_PER(HP), .SCAN_GAP(GAP)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_scan_en(scan_en),
    .bus      (bus)
  );

  // Pad shift registers: parallel load while latched, shift toward bit 0 on clock rise.
  logic [7:0] pad1_n = 8'hFF, pad2_n = 8'hFF, sr1 = 8'hFF, sr2 = 8'hFF;
  logic [3:0] aux_n = 4'hF;
  always @(posedge bus.o_pad_latch or posedge bus.o_pad_clk) begin
    if (bus.o_pad_latch) begin
      sr1 <= pad1_n;
      sr2 <= pad2_n;
    end else begin
      sr1 <= {1'b1, sr1[7:1]};
      sr2 <= {1'b1, sr2[7:1]};
    end
  end
  assign bus.i_pad1_data = sr1[0];
  assign bus.i_pad2_data = sr2[0];
  assign bus.i_aux_n     = aux_n;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  logic [19:0] q[$];
  logic seen_done;
  int t_rel, hi_cnt, rise_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_latch(input string tag, output int t);
    logic got;
    got = 1'b0;
    seen_done = 1'b0;
    t = 0;
    for (int i = 0; i < 2 * GAP + 10; i++) begin
      @(negedge clk);
      if (bus.o_scan_done) seen_done = 1'b1;
      if (bus.o_pad_latch) begin
        got = 1'b1;
        t = cyc;
        break;
      end
    end
    chk({tag, " latch seen"}, 32'(got), 32'd1);
  endtask

  // act: 0 plain scan, 1 drop scan_en mid-scan, 2 reset pulse during SHIFT_HI bit 5
  task automatic run_scan(input string tag, input int act, output int t_lat, output int t_done);
    logic got, prev, aborted;
    logic [19:0] e;
    int falls;
    wait_latch(tag, t_lat);
    got = 1'b0; aborted = 1'b0; t_done = 0;
    hi_cnt = 1; rise_cnt = 0; falls = 0;
    prev = bus.o_pad_clk;
    for (int i = 0; i < 40 * HP; i++) begin
      @(negedge clk);
      if (bus.o_pad_latch) hi_cnt++;
      if (bus.o_pad_clk && !prev) rise_cnt++;
      if (!bus.o_pad_clk && prev) falls++;
      prev = bus.o_pad_clk;
      if (act == 1 && falls == 3) scan_en = 1'b0;
      if (act == 2 && rise_cnt == 5) begin
        rst = 1'b1;
        #1;
        chk({tag, " rst vec1"}, 32'(bus.o_jp_vec_1p), 32'h000);
        chk({tag, " rst vec2"}, 32'(bus.o_jp_vec_2p), 32'h000);
        chk({tag, " rst pad_clk"}, 32'(bus.o_pad_clk), 32'd1);
        chk({tag, " rst latch"}, 32'(bus.o_pad_latch), 32'd0);
        chk({tag, " rst done"}, 32'(bus.o_scan_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        t_rel = cyc;
        aborted = 1'b1;
        break;
      end
      if (bus.o_scan_done) begin
        got = 1'b1;
        t_done = cyc;
        break;
      end
    end
    if (!aborted) begin
      chk({tag, " done seen"}, 32'(got), 32'd1);
      chk({tag, " queue has entry"}, 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({tag, " vec1"}, 32'(bus.o_jp_vec_1p), 32'(e[19:10]));
        chk({tag, " vec2"}, 32'(bus.o_jp_vec_2p), 32'(e[9:0]));
      end
      @(negedge clk);
      chk({tag, " done one cycle"}, 32'(bus.o_scan_done), 32'd0);
    end
  endtask

  initial begin
    int tl1, td1, tl2, td2, tl, td, t0, lat_cnt, done_cnt;

    repeat (3) @(negedge clk);
    chk("reset vec1", 32'(bus.o_jp_vec_1p), 32'h000);
    chk("reset vec2", 32'(bus.o_jp_vec_2p), 32'h000);
    chk("reset done", 32'(bus.o_scan_done), 32'd0);
    chk("reset latch", 32'(bus.o_pad_latch), 32'd0);
    chk("reset pad_clk", 32'(bus.o_pad_clk), 32'd1);

    // Pad1 A+Start+Right, pad2 idle
    pad1_n = 8'h76; pad2_n = 8'hFF; aux_n = 4'hF;
    q.push_back({10'h089, 10'h000});
    scan_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    t_rel = cyc;
    run_scan("s1", 0, tl1, td1);
    chk("s1 first latch delay", 32'(tl1 - t_rel), 32'(GAP));
    chk("s1 latch width", 32'(hi_cnt), 32'(2 * HP));
    chk("s1 pad_clk rises", 32'(rise_cnt), 32'd7);
    chk("s1 scan length", 32'(td1 - tl1), 32'(17 * HP));

    // Aux keys plus pad2 B+Up
    pad1_n = 8'hFF; pad2_n = 8'hED; aux_n = 4'b0110;
    q.push_back({10'h100, 10'h212});
    run_scan("s2", 0, tl2, td2);
    chk("s2 gap after done", 32'(tl2 - td1), 32'(GAP));
    aux_n = 4'hF; pad2_n = 8'hFF;
    repeat (50) @(negedge clk);
    chk("hold vec1", 32'(bus.o_jp_vec_1p), 32'h100);
    chk("hold vec2", 32'(bus.o_jp_vec_2p), 32'h212);

    // scan_en dropped mid-scan
    pad1_n = 8'hA5;
    q.push_back({10'h05A, 10'h000});
    run_scan("s3", 1, tl, td);
    lat_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 3 * GAP; i++) begin
      @(negedge clk);
      if (bus.o_pad_latch) lat_cnt++;
      if (bus.o_scan_done) done_cnt++;
    end
    chk("disabled latch count", 32'(lat_cnt), 32'd0);
    chk("disabled done count", 32'(done_cnt), 32'd0);

    // Re-enable: gap already expired, so latch follows at once
    pad1_n = 8'h00;
    q.push_back({10'h0FF, 10'h000});
    scan_en = 1'b1;
    t0 = cyc;
    run_scan("s4", 0, tl, td);
    chk("s4 enable latency", 32'(tl - t0), 32'd1);

    // Reset during SHIFT_HI bit 5 with 0x0FF displayed
    run_scan("s5", 2, tl, td);
    pad1_n = 8'hFF; pad2_n = 8'hFF; aux_n = 4'hF;
    q.push_back({10'h000, 10'h000});
    run_scan("s6", 0, tl, td);
    chk("s6 latch after reset", 32'(tl - t_rel), 32'(GAP));
    chk("s6 no stale done", 32'(seen_done), 32'd0);
    chk("queue drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
